// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the nibble-serial add/subtract controller.
package adder_seq_pkg;

  localparam int DEF_N_NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder4_cla.sv
// 4-bit carry-lookahead adder slice; the only carry chain in the controller.
module adder4_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead terms so no carry ripples between bit positions.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/adder16_seq_ctrl.sv
// Nibble-serial W-bit add/subtract: one 4-bit CLA reused LSB nibble first.
// state | meaning: IDLE ready for start | RUN one nibble per cycle | DONE result valid pulse
module adder16_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int N_NIB = DEF_N_NIB
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [4*N_NIB-1:0] a,
  input  logic [4*N_NIB-1:0] b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [4*N_NIB-1:0] sum,
  output logic               co,
  output logic               ovf
);

  localparam int W  = 4 * N_NIB;
  localparam int IW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_NIB - 1);

  state_t         state, state_n;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [W-1:0]   a_q, b_q, res_q, res_n;
  logic [3:0]     nib_s;
  logic           nib_co;
  logic           last;

  assign last = (idx == LAST);

  adder4_cla u_cla (
    .a  (a_q[{idx, 2'b00} +: 4]),
    .b  (b_q[{idx, 2'b00} +: 4]),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    res_n = res_q;
    res_n[{idx, 2'b00} +: 4] = nib_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // B is stored pre-inverted and the carry seeded with sub, so subtraction is A + ~B + 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      sum   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        a_q   <= a;
        b_q   <= b ^ {W{sub}};
        carry <= sub;
        idx   <= '0;
      end
    end else if (state == RUN) begin
      res_q <= res_n;
      carry <= nib_co;
      if (last) begin
        idx <= '0;
        sum <= res_n;
        co  <= nib_co;
        ovf <= (a_q[W-1] == b_q[W-1]) && (res_n[W-1] != a_q[W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder16_seq_ctrl.sv
// Scoreboard bench for adder16_seq_ctrl at the default 4-nibble width.
module tb_adder16_seq_ctrl;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  adder16_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    exp_t         m;
    logic [W-1:0] bb;
    logic [W:0]   t;
    bb    = sv ? ~bv : bv;
    t     = {1'b0, av} + {1'b0, bb} + (W+1)'(sv);
    m.sum = t[W-1:0];
    m.co  = t[W];
    m.ovf = (av[W-1] == bb[W-1]) && (t[W-1] != av[W-1]);
    return m;
  endfunction

  // Entered at the first negedge after acceptance; expects DONE on the 5th busy sample.
  task automatic wait_result(input string name);
    int   n;
    exp_t e;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
        errors++;
        $display("FAIL %s busy cycle %0d: busy=%b ready=%b required busy=1 ready=0", name, n, busy, ready);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1 || n != 5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: done=%b busy=%b at cycle %0d required done=1 busy=1 at cycle 5", name, done, busy, n);
    end
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty: got sum=%h required an expected entry", name, sum);
      return;
    end
    e = q.pop_front();
    checks++;
    if (sum !== e.sum || co !== e.co || ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s result: sum=%h co=%b ovf=%b required sum=%h co=%b ovf=%b",
               name, sum, co, ovf, e.sum, e.co, e.ovf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || sum !== e.sum || co !== e.co || ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s after done: done=%b ready=%b busy=%b sum=%h required done=0 ready=1 busy=0 sum=%h",
               name, done, ready, busy, sum, e.sum);
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input string name);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s not ready at start: ready=%b required 1", name, ready);
    end
    a     = av;
    b     = bv;
    sub   = sv;
    start = 1'b1;
    q.push_back(model(av, bv, sv));
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
    wait_result(name);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b busy=%b done=%b required 1 0 0", ready, busy, done);
    end
    checks++;
    if (sum !== '0 || co !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: sum=%h co=%b ovf=%b required 0000 0 0", sum, co, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    run_op(16'h1234, 16'h0FFF, 1'b0, "add_basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, "add_carry_chain");
    run_op(16'h7FFF, 16'h0001, 1'b0, "add_overflow");
  endtask

  task automatic test_sub();
    run_op(16'h0005, 16'h0007, 1'b1, "sub_borrow");
    run_op(16'h8000, 16'h0001, 1'b1, "sub_overflow");
    run_op(16'h4321, 16'h4321, 1'b1, "sub_equal");
  endtask

  task automatic test_back_to_back();
    a     = 16'h1234;
    b     = 16'h0FFF;
    sub   = 1'b0;
    start = 1'b1;
    q.push_back(model(16'h1234, 16'h0FFF, 1'b0));
    @(negedge clk);
    a = 16'hAAAA;
    b = 16'h5555;
    wait_result("b2b_first");
    q.push_back(model(16'hAAAA, 16'h5555, 1'b0));
    @(negedge clk);
    start = 1'b0;
    wait_result("b2b_second");
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    a     = 16'h0F0F;
    b     = 16'h0101;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (sum !== '0 || co !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: sum=%h co=%b ovf=%b required 0000 0 0", sum, co, ovf);
    end
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: ready=%b busy=%b done=%b required 1 0 0", ready, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1 || busy !== 1'b0) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: activity seen=%b required 0", saw_done);
    end
    run_op(16'h0001, 16'h0001, 1'b0, "post_reset_add");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
